// File: rtl/toast_mem_responder_if.sv
// Bus bundle between the core and toast_mem_responder.
// Carries the IMEM fetch port, the DMEM load/store port and status flags.
interface toast_mem_if;
   logic [31:0] IMEM_addr;
   logic [31:0] IMEM_data;
   logic [31:0] DMEM_addr;
   logic [31:0] DMEM_wr_data;
   logic        DMEM_wr_en;
   logic        DMEM_rst;
   logic [31:0] DMEM_rd_data;
   logic        Halt;
   logic [31:0] Halt_code;
   logic        Bus_error;

   modport master (
      output IMEM_addr, DMEM_addr, DMEM_wr_data, DMEM_wr_en, DMEM_rst,
      input  IMEM_data, DMEM_rd_data, Halt, Halt_code, Bus_error
   );

   modport slave (
      input  IMEM_addr, DMEM_addr, DMEM_wr_data, DMEM_wr_en, DMEM_rst,
      output IMEM_data, DMEM_rd_data, Halt, Halt_code, Bus_error
   );
endinterface

// File: rtl/toast_mem_responder.sv
// Dual-port word RAM plus TOHOST/CYCLE/SCRATCH MMIO window.
// Both ports have 1-cycle registered read latency, read-first on writes.
module toast_mem_responder #(
   parameter int          DEPTH_WORDS = 4096,
   parameter logic [31:0] MMIO_BASE   = 32'h8000_0000,
   parameter string       INIT_FILE   = ""
) (
   input logic         Clk,
   input logic         Reset,
   toast_mem_if.slave  bus
);

   localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [30:0] RAM_WORDS = 31'(DEPTH_WORDS);
   localparam logic [29:0] MMIO_W    = MMIO_BASE[31:2];
   localparam logic [31:0] NOP       = 32'h0000_0013;

   logic [31:0] mem [DEPTH_WORDS];

   logic [29:0]   i_word, d_word;
   logic [AW-1:0] i_idx, d_idx;
   logic          i_ram, d_ram;
   logic          d_tohost, d_cycle, d_scratch, d_unmapped;
   logic          unused_ok;

   assign i_word     = bus.IMEM_addr[31:2];
   assign d_word     = bus.DMEM_addr[31:2];
   assign i_idx      = bus.IMEM_addr[AW+1:2];
   assign d_idx      = bus.DMEM_addr[AW+1:2];
   assign i_ram      = {1'b0, i_word} < RAM_WORDS;
   assign d_ram      = {1'b0, d_word} < RAM_WORDS;
   assign d_tohost   = d_word == MMIO_W;
   assign d_cycle    = d_word == MMIO_W + 30'd1;
   assign d_scratch  = d_word == MMIO_W + 30'd2;
   assign d_unmapped = !(d_ram || d_tohost || d_cycle || d_scratch);
   assign unused_ok  = ^{bus.IMEM_addr[1:0], bus.DMEM_addr[1:0]};

   logic [31:0] imem_data_q, imem_data_d;
   logic [31:0] dmem_rd_q, dmem_rd_d;
   logic [31:0] cycle_q, cycle_d;
   logic [31:0] scratch_q, scratch_d;
   logic [31:0] halt_code_q, halt_code_d;
   logic        halt_q, halt_d;
   logic        bus_error_q, bus_error_d;

   // Next-state for read data, MMIO registers and sticky flags.
   always_comb begin
      imem_data_d = NOP;
      dmem_rd_d   = '0;
      cycle_d     = halt_q ? cycle_q : cycle_q + 32'd1;
      scratch_d   = scratch_q;
      halt_d      = halt_q;
      halt_code_d = halt_code_q;
      bus_error_d = bus_error_q;

      if (i_ram) imem_data_d = mem[i_idx];
      else       bus_error_d = 1'b1;

      unique case (1'b1)
         d_ram:     dmem_rd_d = mem[d_idx];
         d_tohost:  dmem_rd_d = halt_code_q;
         d_cycle:   dmem_rd_d = cycle_q;
         d_scratch: dmem_rd_d = scratch_q;
         default:   dmem_rd_d = '0;
      endcase
      if (bus.DMEM_rst) dmem_rd_d = '0;
      if (d_unmapped)   bus_error_d = 1'b1;

      if (bus.DMEM_wr_en) begin
         if (d_tohost && !halt_q) begin
            halt_d      = 1'b1;
            halt_code_d = bus.DMEM_wr_data;
         end
         if (d_scratch) scratch_d = bus.DMEM_wr_data;
      end
   end

   // RAM write port; reads above see the pre-write word.
   always_ff @(posedge Clk) begin
      if (bus.DMEM_wr_en && d_ram) mem[d_idx] <= bus.DMEM_wr_data;
   end

   // Register bank with asynchronous reset.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         imem_data_q <= NOP;
         dmem_rd_q   <= '0;
         cycle_q     <= '0;
         scratch_q   <= '0;
         halt_q      <= 1'b0;
         halt_code_q <= '0;
         bus_error_q <= 1'b0;
      end else begin
         imem_data_q <= imem_data_d;
         dmem_rd_q   <= dmem_rd_d;
         cycle_q     <= cycle_d;
         scratch_q   <= scratch_d;
         halt_q      <= halt_d;
         halt_code_q <= halt_code_d;
         bus_error_q <= bus_error_d;
      end
   end

   assign bus.IMEM_data    = imem_data_q;
   assign bus.DMEM_rd_data = dmem_rd_q;
   assign bus.Halt         = halt_q;
   assign bus.Halt_code    = halt_code_q;
   assign bus.Bus_error    = bus_error_q;

endmodule

// File: tb/tb_toast_mem_responder.sv
// Self-checking bench for toast_mem_responder.
// Directed vector table, random traffic vs. a word-array model, corner sequences.
module tb_toast_mem_responder;

   localparam logic [31:0] MB  = 32'h8000_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam int          RB  = 32'h100;

   logic Clk = 1'b0;
   logic Reset;
   int   total = 0;
   int   bad = 0;

   always #5 Clk = ~Clk;

   toast_mem_if bus ();

   toast_mem_responder #(
      .DEPTH_WORDS(4096),
      .MMIO_BASE(MB),
      .INIT_FILE("")
   ) dut (
      .Clk(Clk),
      .Reset(Reset),
      .bus(bus)
   );

   typedef struct {
      logic        we;
      logic        rst;
      logic [31:0] daddr;
      logic [31:0] wdata;
      logic [31:0] iaddr;
      logic        ci;
      logic [31:0] ei;
      logic        cd;
      logic [31:0] ed;
   } vec_t;

   vec_t tbl [14];

   logic [31:0] m [16];
   logic [31:0] s_m;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive(input logic we, input logic rst, input logic [31:0] da,
                        input logic [31:0] wd, input logic [31:0] ia);
      @(negedge Clk);
      bus.DMEM_wr_en   = we;
      bus.DMEM_rst     = rst;
      bus.DMEM_addr    = da;
      bus.DMEM_wr_data = wd;
      bus.IMEM_addr    = ia;
   endtask

   initial begin
      logic [31:0] exp_i, exp_d, wd, da, ia, hcyc;
      logic        we, rst, cd;
      int          dk, ik, kind;

      tbl[0]  = '{1'b1, 1'b0, 32'h0,       32'h0050_0093, 32'h4,    1'b0, 32'h0,         1'b0, 32'h0};
      tbl[1]  = '{1'b1, 1'b0, 32'h10,      32'h1111_1111, 32'h0,    1'b1, 32'h0050_0093, 1'b0, 32'h0};
      tbl[2]  = '{1'b1, 1'b0, 32'h10,      32'hDEAD_BEEF, 32'h10,   1'b1, 32'h1111_1111, 1'b1, 32'h1111_1111};
      tbl[3]  = '{1'b0, 1'b0, 32'h12,      32'h0,         32'h13,   1'b1, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF};
      tbl[4]  = '{1'b1, 1'b1, MB + 32'h8,  32'h55,        32'h0,    1'b1, 32'h0050_0093, 1'b1, 32'h0};
      tbl[5]  = '{1'b0, 1'b0, MB + 32'h8,  32'h0,         32'h10,   1'b1, 32'hDEAD_BEEF, 1'b1, 32'h55};
      tbl[6]  = '{1'b0, 1'b1, 32'h10,      32'h0,         32'h10,   1'b1, 32'hDEAD_BEEF, 1'b1, 32'h0};
      tbl[7]  = '{1'b1, 1'b0, MB + 32'h4,  32'h1234,      32'h0,    1'b1, 32'h0050_0093, 1'b0, 32'h0};
      tbl[8]  = '{1'b0, 1'b0, MB,          32'h0,         32'h0,    1'b0, 32'h0,         1'b1, 32'h0};
      tbl[9]  = '{1'b1, 1'b0, MB + 32'h8,  32'hA5A5,      32'h0,    1'b0, 32'h0,         1'b1, 32'h55};
      tbl[10] = '{1'b0, 1'b0, MB + 32'hB,  32'h0,         32'h0,    1'b0, 32'h0,         1'b1, 32'hA5A5};
      tbl[11] = '{1'b1, 1'b0, 32'h3FFC,    32'hCAFE_F00D, 32'h0,    1'b0, 32'h0,         1'b0, 32'h0};
      tbl[12] = '{1'b0, 1'b0, 32'h3FFC,    32'h0,         32'h3FFC, 1'b1, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D};
      tbl[13] = '{1'b0, 1'b0, 32'h10,      32'h0,         32'h0,    1'b1, 32'h0050_0093, 1'b1, 32'hDEAD_BEEF};

      Reset            = 1'b1;
      bus.DMEM_wr_en   = 1'b0;
      bus.DMEM_rst     = 1'b0;
      bus.DMEM_addr    = 32'h0;
      bus.DMEM_wr_data = 32'h0;
      bus.IMEM_addr    = 32'h0;
      @(negedge Clk);
      @(negedge Clk);
      chk("rst_imem", bus.IMEM_data, NOP);
      chk("rst_dmem", bus.DMEM_rd_data, 32'h0);
      chk("rst_halt", 32'(bus.Halt), 32'h0);
      chk("rst_code", bus.Halt_code, 32'h0);
      chk("rst_berr", 32'(bus.Bus_error), 32'h0);
      Reset = 1'b0;

      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].we, tbl[i].rst, tbl[i].daddr, tbl[i].wdata, tbl[i].iaddr);
         step();
         if (tbl[i].ci) chk($sformatf("vec%0d_imem", i), bus.IMEM_data, tbl[i].ei);
         if (tbl[i].cd) chk($sformatf("vec%0d_dmem", i), bus.DMEM_rd_data, tbl[i].ed);
         chk($sformatf("vec%0d_berr", i), 32'(bus.Bus_error), 32'h0);
      end

      for (int k = 0; k < 16; k++) begin
         m[k] = $urandom;
         drive(1'b1, 1'b0, 32'(RB + 4 * k), m[k], 32'h0);
         step();
      end
      s_m = $urandom;
      drive(1'b1, 1'b0, MB + 32'h8, s_m, 32'h0);
      step();

      for (int n = 0; n < 400; n++) begin
         kind = $urandom_range(0, 9);
         dk   = $urandom_range(0, 15);
         ik   = $urandom_range(0, 15);
         we   = ($urandom_range(0, 2) == 0);
         rst  = ($urandom_range(0, 7) == 0);
         wd   = $urandom;
         ia   = 32'(RB + 4 * ik) | 32'($urandom_range(0, 3));
         if (kind < 7)       da = 32'(RB + 4 * dk);
         else if (kind < 9)  da = MB + 32'h8;
         else                da = MB + 32'h4;
         da    = da | 32'($urandom_range(0, 3));
         exp_i = m[ik];
         cd    = 1'b1;
         if (rst)           exp_d = 32'h0;
         else if (kind < 7) exp_d = m[dk];
         else if (kind < 9) exp_d = s_m;
         else begin
            exp_d = 32'h0;
            cd    = 1'b0;
         end
         if (we && kind < 7)      m[dk] = wd;
         else if (we && kind < 9) s_m   = wd;
         drive(we, rst, da, wd, ia);
         step();
         chk($sformatf("rnd%0d_imem", n), bus.IMEM_data, exp_i);
         if (cd) chk($sformatf("rnd%0d_dmem", n), bus.DMEM_rd_data, exp_d);
      end
      chk("rnd_berr", 32'(bus.Bus_error), 32'h0);

      drive(1'b0, 1'b0, MB + 32'h4, 32'h0, 32'h0);
      force dut.cycle_q = 32'hFFFF_FFFE;
      #1;
      release dut.cycle_q;
      step();
      chk("wrap_fffe", bus.DMEM_rd_data, 32'hFFFF_FFFE);
      step();
      chk("wrap_ffff", bus.DMEM_rd_data, 32'hFFFF_FFFF);
      step();
      chk("wrap_0", bus.DMEM_rd_data, 32'h0);
      step();
      chk("wrap_1", bus.DMEM_rd_data, 32'h1);
      step();

      @(negedge Clk);
      Reset = 1'b1;
      #1;
      chk("arst_dmem", bus.DMEM_rd_data, 32'h0);
      chk("arst_imem", bus.IMEM_data, NOP);
      @(negedge Clk);
      Reset = 1'b0;
      step();
      chk("cyc_e1", bus.DMEM_rd_data, 32'h0);
      step();
      chk("cyc_e2", bus.DMEM_rd_data, 32'h1);

      drive(1'b1, 1'b0, MB, 32'h1, 32'h0);
      step();
      hcyc = 32'd3;
      chk("tohost1_rd", bus.DMEM_rd_data, 32'h0);
      chk("tohost1_halt", 32'(bus.Halt), 32'h1);
      chk("tohost1_code", bus.Halt_code, 32'h1);
      drive(1'b1, 1'b0, MB, 32'h2, 32'h0);
      step();
      chk("tohost2_rd", bus.DMEM_rd_data, 32'h1);
      chk("tohost2_code", bus.Halt_code, 32'h1);
      drive(1'b0, 1'b0, MB + 32'h4, 32'h0, 32'h0);
      step();
      chk("frz_a", bus.DMEM_rd_data, hcyc);
      step();
      chk("frz_b", bus.DMEM_rd_data, hcyc);
      chk("frz_berr", 32'(bus.Bus_error), 32'h0);

      drive(1'b0, 1'b0, 32'h4000, 32'h0, MB);
      step();
      chk("oor_dmem", bus.DMEM_rd_data, 32'h0);
      chk("oor_imem", bus.IMEM_data, NOP);
      chk("oor_berr", 32'(bus.Bus_error), 32'h1);
      drive(1'b0, 1'b0, 32'h10, 32'h0, 32'h0);
      step();
      chk("ret_dmem", bus.DMEM_rd_data, 32'hDEAD_BEEF);
      chk("ret_imem", bus.IMEM_data, 32'h0050_0093);
      chk("sticky_berr", 32'(bus.Bus_error), 32'h1);
      chk("sticky_halt", 32'(bus.Halt), 32'h1);

      @(negedge Clk);
      Reset = 1'b1;
      #1;
      chk("clr_berr", 32'(bus.Bus_error), 32'h0);
      chk("clr_halt", 32'(bus.Halt), 32'h0);
      chk("clr_code", bus.Halt_code, 32'h0);
      @(negedge Clk);
      Reset = 1'b0;
      drive(1'b0, 1'b0, MB + 32'h8, 32'h0, 32'h0);
      step();
      chk("scr_rst", bus.DMEM_rd_data, 32'h0);
      drive(1'b0, 1'b0, MB + 32'hC, 32'h0, 32'h0);
      step();
      chk("mmio_end_dmem", bus.DMEM_rd_data, 32'h0);
      chk("mmio_end_berr", 32'(bus.Bus_error), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
